// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central hazard and sequencing controller for a 5-stage MIPS pipeline.
// Generates the PC / IF/ID / ID/Ex stall and flush controls from three sources:
//   - load-use hazards between the load in Ex and the instruction in ID,
//   - Ex-stage branch/jump redirects (highest priority),
//   - HI/LO interlock while the multi-cycle multiply/divide unit is busy.
//
// Parameters:
//   MDU_LAT  MDU latency in cycles, counted from the cycle its start is in Ex (1..16)
//   CNT_W    width of the performance counters
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ID_Rs, ID_Rt      source register fields of the instruction in ID
//   ID_useRs/useRt    ID instruction actually reads rs / rt
//   ID_hilo_use       ID instruction is mult/div/mfhi/mflo/mthi/mtlo
//   Ex_Rt             load destination register in Ex
//   Ex_MemRead        Ex instruction is a load
//   Ex_mdu_start      Ex instruction launches the MDU
//   Ex_redirect       Ex resolved a mispredict or jr/jalr redirect
//   PC_stall          hold PC
//   IFID_stall        hold the IF/ID register
//   IFID_flush        clear the IF/ID register
//   IDEx_Flush        clear ID/Ex (insert a bubble)
//   mdu_busy          MDU sequencer is in BUSY
//   stall_cycles      number of cycles with PC_stall=1 (wraps)
//   flush_events      number of cycles with Ex_redirect=1 (wraps)
//
// Build option:
//   HAZ_PERF_CNT_EN   when defined, the two performance counters are built;
//                     otherwise stall_cycles and flush_events are tied to 0.
//
// The stall/flush controls are deliberately combinational: the pipeline must
// see a hazard in the same cycle it is detected, and they are re-evaluated
// every cycle. They are forced to 0 while rst is high.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_useRs,
    input  logic             ID_useRt,
    input  logic             ID_hilo_use,
    input  logic [4:0]       Ex_Rt,
    input  logic             Ex_MemRead,
    input  logic             Ex_mdu_start,
    input  logic             Ex_redirect,
    output logic             PC_stall,
    output logic             IFID_stall,
    output logic             IFID_flush,
    output logic             IDEx_Flush,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int CW = $clog2(MDU_LAT + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_lu;
    logic            w_hl;

    // Hazard detection: register $zero never creates a dependency.
    assign w_lu = Ex_MemRead && (Ex_Rt != 5'd0) &&
                  ((ID_useRs && (ID_Rs == Ex_Rt)) || (ID_useRt && (ID_Rt == Ex_Rt)));

    // A HI/LO op must wait while an MDU op is launching or still in flight.
    assign w_hl = ID_hilo_use && (Ex_mdu_start || (r_state == ST_BUSY));

    assign mdu_busy = (r_state == ST_BUSY);

    // MDU sequencer state and down-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // MDU sequencer next-state: a start launched from RUN occupies
    // MDU_LAT-1 further cycles in BUSY; a redirect does not cancel it and a
    // start seen while already BUSY is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (Ex_mdu_start && (MDU_LAT > 1)) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            ST_BUSY: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Stall/flush priority: redirect discards the ID instruction, so its
    // hazards are irrelevant; otherwise any hazard freezes PC and IF/ID and
    // bubbles ID/Ex.
    always_comb begin
        PC_stall   = 1'b0;
        IFID_stall = 1'b0;
        IFID_flush = 1'b0;
        IDEx_Flush = 1'b0;
        if (rst) begin
            PC_stall   = 1'b0;
            IFID_stall = 1'b0;
            IFID_flush = 1'b0;
            IDEx_Flush = 1'b0;
        end else if (Ex_redirect) begin
            IFID_flush = 1'b1;
            IDEx_Flush = 1'b1;
        end else if (w_lu || w_hl) begin
            PC_stall   = 1'b1;
            IFID_stall = 1'b1;
            IDEx_Flush = 1'b1;
        end else begin
            PC_stall   = 1'b0;
            IFID_stall = 1'b0;
            IFID_flush = 1'b0;
            IDEx_Flush = 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    // Performance counters; both wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= {CNT_W{1'b0}};
            r_flush_events <= {CNT_W{1'b0}};
        end else begin
            if (PC_stall) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (Ex_redirect) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    assign stall_cycles = {CNT_W{1'b0}};
    assign flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scoreboard bench for pipe_hazard_ctrl (MDU_LAT=4, CNT_W=32).
// Each stimulus cycle pushes its hand-computed expected outputs into a queue;
// a monitor on the falling clock edge pops and compares.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic [4:0]       ID_Rs, ID_Rt, Ex_Rt;
    logic             ID_useRs, ID_useRt, ID_hilo_use;
    logic             Ex_MemRead, Ex_mdu_start, Ex_redirect;
    logic             PC_stall, IFID_stall, IFID_flush, IDEx_Flush, mdu_busy;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_useRs     (ID_useRs),
        .ID_useRt     (ID_useRt),
        .ID_hilo_use  (ID_hilo_use),
        .Ex_Rt        (Ex_Rt),
        .Ex_MemRead   (Ex_MemRead),
        .Ex_mdu_start (Ex_mdu_start),
        .Ex_redirect  (Ex_redirect),
        .PC_stall     (PC_stall),
        .IFID_stall   (IFID_stall),
        .IFID_flush   (IFID_flush),
        .IDEx_Flush   (IDEx_Flush),
        .mdu_busy     (mdu_busy),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    typedef struct {
        string            name;
        logic [3:0]       ctl;   // {PC_stall, IFID_stall, IFID_flush, IDEx_Flush}
        logic             busy;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fe;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int unsigned tally_sc = 0;
    int unsigned tally_fe = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [3:0] act;
            e   = sb_q.pop_front();
            act = {PC_stall, IFID_stall, IFID_flush, IDEx_Flush};
            n_cmp++;
            if (act !== e.ctl) begin
                n_fail++;
                $display("FAIL %s ctl {pcs,ifs,iff,idf}: got %b expected %b", e.name, act, e.ctl);
            end
            n_cmp++;
            if (mdu_busy !== e.busy) begin
                n_fail++;
                $display("FAIL %s mdu_busy: got %b expected %b", e.name, mdu_busy, e.busy);
            end
            n_cmp++;
            if (stall_cycles !== e.sc) begin
                n_fail++;
                $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, stall_cycles, e.sc);
            end
            n_cmp++;
            if (flush_events !== e.fe) begin
                n_fail++;
                $display("FAIL %s flush_events: got %0d expected %0d", e.name, flush_events, e.fe);
            end
        end
    end

    // One cycle of stimulus plus its expected outputs. mid_rst asserts rst
    // part-way through the cycle, away from both clock edges.
    task automatic step(input string nm, input logic a_rst, input logic a_mid_rst,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic hilo,
                        input logic [4:0] ert, input logic mrd,
                        input logic start, input logic redir,
                        input logic [3:0] exp_ctl, input logic exp_busy);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = a_rst;
        ID_Rs        = rs;
        ID_Rt        = rt;
        ID_useRs     = urs;
        ID_useRt     = urt;
        ID_hilo_use  = hilo;
        Ex_Rt        = ert;
        Ex_MemRead   = mrd;
        Ex_mdu_start = start;
        Ex_redirect  = redir;
        if (a_mid_rst) begin
            #1;
            rst = 1'b1;
        end
        if (a_rst || a_mid_rst) begin
            tally_sc = 0;
            tally_fe = 0;
        end
        e.name = nm;
        e.ctl  = exp_ctl;
        e.busy = exp_busy;
`ifdef HAZ_PERF_CNT_EN
        e.sc   = CNT_W'(tally_sc);
        e.fe   = CNT_W'(tally_fe);
`else
        e.sc   = {CNT_W{1'b0}};
        e.fe   = {CNT_W{1'b0}};
`endif
        sb_q.push_back(e);
        if (!(a_rst || a_mid_rst)) begin
            if (exp_ctl[3]) tally_sc++;
            if (redir)      tally_fe++;
        end
    endtask

    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_STALL = 4'b1101;
    localparam logic [3:0] C_FLUSH = 4'b0011;

    initial begin
        rst = 1'b1;
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_useRs = 1'b0; ID_useRt = 1'b0; ID_hilo_use = 1'b0;
        Ex_Rt = 5'd0; Ex_MemRead = 1'b0; Ex_mdu_start = 1'b0; Ex_redirect = 1'b0;

        //    name            rst   mid   rs     rt     urs   urt   hilo  ert    mrd   start redir exp      busy
        step("rst_gate",      1'b1, 1'b0, 5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 1'b1, 1'b0, C_NONE,  1'b0);
        step("idle",          1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE,  1'b0);
        step("lu_rs",         1'b0, 1'b0, 5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 5'd8,  1'b1, 1'b0, 1'b0, C_STALL, 1'b0);
        step("lu_release",    1'b0, 1'b0, 5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 5'd8,  1'b0, 1'b0, 1'b0, C_NONE,  1'b0);
        step("lu_reg0",       1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, C_NONE,  1'b0);
        step("lu_rt_unused",  1'b0, 1'b0, 5'd0,  5'd9,  1'b0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, C_NONE,  1'b0);
        step("lu_rt",         1'b0, 1'b0, 5'd0,  5'd9,  1'b0, 1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, C_STALL, 1'b0);
        step("hilo_run",      1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE,  1'b0);
        step("mdu_T",         1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, C_STALL, 1'b0);
        step("mdu_T1",        1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_STALL, 1'b1);
        step("mdu_T2",        1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_STALL, 1'b1);
        step("mdu_T3",        1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_STALL, 1'b1);
        step("mdu_T4",        1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE,  1'b0);
        step("redir_lu",      1'b0, 1'b0, 5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 5'd8,  1'b1, 1'b0, 1'b1, C_FLUSH, 1'b0);
        step("after_redir",   1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE,  1'b0);
        step("rb_T",          1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, C_NONE,  1'b0);
        step("rb_T1",         1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE,  1'b1);
        step("rb_T2_redir",   1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, C_FLUSH, 1'b1);
        step("rb_T3",         1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE,  1'b1);
        step("rb_T4",         1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE,  1'b0);
        step("ar_T",          1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, C_NONE,  1'b0);
        step("ar_T1",         1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE,  1'b1);
        step("ar_T2_rst",     1'b0, 1'b1, 5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, C_NONE,  1'b0);
        step("ar_released",   1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE,  1'b0);
        step("ar_run_hold",   1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE,  1'b0);
        step("final_lu",      1'b0, 1'b0, 5'd3,  5'd0,  1'b1, 1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, C_STALL, 1'b0);
        step("final_cnt",     1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, C_NONE,  1'b0);

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required normal end");
        $fatal(1, "watchdog expired");
    end

endmodule
